// File: rtl/router_pkg.sv
// Shared types and helpers for the serial packet router.
// Imported by router_rr and rr_arbiter.
package router_pkg;

    localparam int MAX_PORTS = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ARB,
        ST_FWD,
        ST_DROP
    } port_state_e;

    // Address width for a port count; never narrower than one bit.
    function automatic int addr_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starts after
// the last granted requester and wraps; pointer moves only on grant.
module rr_arbiter
    import router_pkg::*;
#(
    parameter int NUM_PORTS = 16,
    parameter int PTR_W     = addr_width(NUM_PORTS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] gnt_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic             found;

    // Pick the lowest requester above the pointer, else the lowest at or below it.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && req_i[i] && (PTR_W'(i) > ptr_q)) begin
                gnt_o[i] = 1'b1;
                ptr_d    = PTR_W'(i);
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && req_i[i] && (PTR_W'(i) <= ptr_q)) begin
                gnt_o[i] = 1'b1;
                ptr_d    = PTR_W'(i);
                found    = 1'b1;
            end
        end
    end

    // Last-grant pointer; starts at the top port so port 0 wins first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= PTR_W'(NUM_PORTS - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/router_rr.sv
// Serial packet router: per-input framing FSMs, per-output
// round-robin arbitration and locks, registered output mux.
module router_rr
    import router_pkg::*;
#(
    parameter int NUM_PORTS = 16,
    parameter int ADDR_W    = addr_width(NUM_PORTS)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_PORTS-1:0] din,
    input  logic [NUM_PORTS-1:0] frame_n,
    input  logic [NUM_PORTS-1:0] valid_n,
    output logic [NUM_PORTS-1:0] dout,
    output logic [NUM_PORTS-1:0] frameo_n,
    output logic [NUM_PORTS-1:0] valido_n,
    output logic [NUM_PORTS-1:0] drop
);

    if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS) begin : g_bad_cfg
        $error("router_rr: NUM_PORTS out of range");
    end

    logic [NUM_PORTS-1:0] fdly_q;
    logic [NUM_PORTS-1:0] drop_q;
    logic [NUM_PORTS-1:0] drop_d;
    logic [NUM_PORTS-1:0] fwd;
    logic [NUM_PORTS-1:0] gnt_in;
    logic [NUM_PORTS-1:0] lock;

    logic [NUM_PORTS-1:0] dst_req [NUM_PORTS];
    logic [NUM_PORTS-1:0] req_out [NUM_PORTS];
    logic [NUM_PORTS-1:0] gnt_out [NUM_PORTS];
    logic [NUM_PORTS-1:0] owner_q [NUM_PORTS];
    logic [NUM_PORTS-1:0] owner_d [NUM_PORTS];

    logic [NUM_PORTS-1:0] dout_q;
    logic [NUM_PORTS-1:0] dout_d;
    logic [NUM_PORTS-1:0] frameo_q;
    logic [NUM_PORTS-1:0] frameo_d;
    logic [NUM_PORTS-1:0] valido_q;
    logic [NUM_PORTS-1:0] valido_d;

    // Delayed frame for edge detect; reset low so a frame in flight is ignored.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fdly_q <= '0;
            drop_q <= '0;
        end else begin
            fdly_q <= frame_n;
            drop_q <= drop_d;
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
        port_state_e       st_q;
        port_state_e       st_d;
        logic [ADDR_W-1:0] addr_q;
        logic [ADDR_W-1:0] addr_d;
        logic [ADDR_W-1:0] shift;
        logic [ADDR_W-1:0] cnt_q;
        logic [ADDR_W-1:0] cnt_d;
        logic              sof;
        logic              drop_c;

        assign sof = fdly_q[i] & ~frame_n[i];

        if (ADDR_W == 1) begin : g_a1
            assign shift = din[i];
        end else begin : g_an
            assign shift = {din[i], addr_q[ADDR_W-1:1]};
        end

        // Framing FSM: collect the address LSB first, request in the pad cycle.
        always_comb begin
            st_d   = st_q;
            addr_d = addr_q;
            cnt_d  = cnt_q;
            drop_c = 1'b0;
            unique case (st_q)
                ST_IDLE: begin
                    if (sof) begin
                        addr_d = shift;
                        cnt_d  = ADDR_W'(1);
                        st_d   = (ADDR_W == 1) ? ST_ARB : ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (frame_n[i]) begin
                        drop_c = 1'b1;
                        st_d   = ST_IDLE;
                    end else begin
                        addr_d = shift;
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_q == ADDR_W'(ADDR_W - 1)) begin
                            st_d = ST_ARB;
                        end
                    end
                end
                ST_ARB: begin
                    if (frame_n[i]) begin
                        drop_c = 1'b1;
                        st_d   = ST_IDLE;
                    end else if (gnt_in[i]) begin
                        st_d = ST_FWD;
                    end else begin
                        drop_c = 1'b1;
                        st_d   = ST_DROP;
                    end
                end
                ST_FWD: begin
                    if (frame_n[i]) begin
                        st_d = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (frame_n[i]) begin
                        st_d = ST_IDLE;
                    end
                end
                default: st_d = ST_IDLE;
            endcase
        end

        // Per-input state, address shifter and bit counter.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                st_q   <= ST_IDLE;
                addr_q <= '0;
                cnt_q  <= '0;
            end else begin
                st_q   <= st_d;
                addr_q <= addr_d;
                cnt_q  <= cnt_d;
            end
        end

        // Out-of-range addresses shift the one-hot out and request nothing.
        assign dst_req[i] = (st_q == ST_ARB && !frame_n[i])
                          ? ({{(NUM_PORTS-1){1'b0}}, 1'b1} << addr_q)
                          : '0;
        assign fwd[i]     = (st_q == ST_FWD);
        assign drop_d[i]  = drop_c;
    end

    // Transpose requests per output; a locked output accepts nobody.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            lock[o]    = |owner_q[o];
            req_out[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                req_out[o][i] = dst_req[i][o] & ~lock[o];
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        rr_arbiter #(
            .NUM_PORTS (NUM_PORTS),
            .PTR_W     (ADDR_W)
        ) u_arb (
            .clk_i  (clock),
            .rst_ni (reset_n),
            .req_i  (req_out[o]),
            .gnt_o  (gnt_out[o])
        );
    end

    // Fold the per-output grants back onto the inputs.
    always_comb begin
        gnt_in = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            gnt_in = gnt_in | gnt_out[o];
        end
    end

    // Owner tracking and output mux; owners are one-hot so OR-reduce selects.
    always_comb begin
        dout_d   = '0;
        frameo_d = '1;
        valido_d = '1;
        for (int o = 0; o < NUM_PORTS; o++) begin
            owner_d[o] = owner_q[o];
            if (|gnt_out[o]) begin
                owner_d[o] = gnt_out[o];
            end else if (|(owner_q[o] & fwd & frame_n)) begin
                owner_d[o] = '0;
            end
            if (|(owner_q[o] & fwd)) begin
                dout_d[o]   = |(owner_q[o] & din);
                frameo_d[o] = |(owner_q[o] & frame_n);
                valido_d[o] = |(owner_q[o] & valid_n);
            end
        end
    end

    // Output locks and registered serial outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                owner_q[o] <= '0;
            end
            dout_q   <= '0;
            frameo_q <= '1;
            valido_q <= '1;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                owner_q[o] <= owner_d[o];
            end
            dout_q   <= dout_d;
            frameo_q <= frameo_d;
            valido_q <= valido_d;
        end
    end

    assign dout     = dout_q;
    assign frameo_n = frameo_q;
    assign valido_n = valido_q;
    assign drop     = drop_q;

endmodule
